nibble_bus_responder: RTL and testbench

//   Far-end responder for the 4-bit nibble link driven by the core-side serializer.

---
 rtl/nibble_bus_pkg.sv | 15 +
 rtl/nibble_bus_rsp_ser.sv | 61 ++++++
 rtl/nibble_bus_responder.sv | 170 +++++++++++++++++
 tb/tb_nibble_bus_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_bus_pkg.sv
// Shared types and constants for the nibble-link responder.
package nibble_bus_pkg;

    localparam int NIBBLE_W = 4;
    localparam logic [NIBBLE_W-1:0] WR_ACK_NIBBLE = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        MEM_REQ,
        MEM_WAIT,
        RSP_SEND
    } nibble_bus_state_e;

endpackage

// File: rtl/nibble_bus_rsp_ser.sv
// Response serializer: loads a word (or a single nibble) and shifts it out
// LSB-first over a valid/ready channel, flagging done on the last accepted nibble.
module nibble_bus_rsp_ser
    import nibble_bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                single_i,
    input  logic [DATA_W-1:0]   word_i,
    output logic [NIBBLE_W-1:0] rsp_nibble_o,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic                done_o
);

    localparam int NIBBLES = DATA_W / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  left_q, left_d;
    logic              valid_q, valid_d;
    logic              fire;

    assign fire         = valid_q && rsp_ready_i;
    assign done_o       = fire && (left_q == '0);
    assign rsp_nibble_o = shreg_q[NIBBLE_W-1:0];
    assign rsp_valid_o  = valid_q;

    always_comb begin
        shreg_d = shreg_q;
        left_d  = left_q;
        valid_d = valid_q;
        if (load_i) begin
            shreg_d = word_i;
            left_d  = single_i ? '0 : CNT_W'(NIBBLES - 1);
            valid_d = 1'b1;
        end else if (fire) begin
            shreg_d = shreg_q >> NIBBLE_W;
            left_d  = left_q - 1'b1;
            if (left_q == '0) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            left_q  <= left_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/nibble_bus_responder.sv
// Far-end nibble-link responder: reassembles write beats into word requests and
// serializes read data back. Define NIBBLE_BUS_WR_ACK_EN to acknowledge writes.
module nibble_bus_responder
    import nibble_bus_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NIBBLE_W-1:0]   link_nibble_i,
    input  logic                  link_strb_i,
    input  logic [ADDR_W-1:0]     link_addr_i,
    input  logic                  link_write_i,
    input  logic                  link_valid_i,
    output logic                  link_ready_o,
    output logic [NIBBLE_W-1:0]   link_rsp_nibble_o,
    output logic                  link_rsp_valid_o,
    input  logic                  link_rsp_ready_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int NIBBLES = DATA_W / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NIBBLES - 1);
    localparam logic [DATA_W-1:0] ACK_WORD = DATA_W'(WR_ACK_NIBBLE);
`ifdef NIBBLE_BUS_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    nibble_bus_state_e state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [NIBBLES-1:0] strb_q, strb_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ser_load, ser_single, ser_done;
    logic [DATA_W-1:0]  ser_word;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        ser_load   = 1'b0;
        ser_single = 1'b0;
        ser_word   = mem_rdata_i;
        unique case (state_q)
            IDLE: begin
                if (link_valid_i) begin
                    addr_d  = link_addr_i;
                    we_d    = link_write_i;
                    wdata_d = '0;
                    strb_d  = '0;
                    cnt_d   = '0;
                    if (link_write_i) begin
                        wdata_d[NIBBLE_W-1:0] = link_nibble_i;
                        strb_d[0]             = link_strb_i;
                        cnt_d                 = CNT_W'(1);
                        state_d               = WR_COLLECT;
                    end else begin
                        state_d = MEM_REQ;
                    end
                end
            end
            WR_COLLECT: begin
                if (link_valid_i) begin
                    wdata_d[cnt_q*NIBBLE_W +: NIBBLE_W] = link_nibble_i;
                    strb_d[cnt_q]                       = link_strb_i;
                    cnt_d                               = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        // Fully unstrobed writes never touch memory.
                        if (|strb_d) begin
                            state_d = MEM_REQ;
                        end else if (WR_ACK) begin
                            ser_load   = 1'b1;
                            ser_single = 1'b1;
                            ser_word   = ACK_WORD;
                            state_d    = RSP_SEND;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            MEM_REQ: begin
                if (mem_gnt_i) begin
                    if (!we_q) begin
                        state_d = MEM_WAIT;
                    end else if (WR_ACK) begin
                        ser_load   = 1'b1;
                        ser_single = 1'b1;
                        ser_word   = ACK_WORD;
                        state_d    = RSP_SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_rvalid_i) begin
                    ser_load = 1'b1;
                    state_d  = RSP_SEND;
                end
            end
            RSP_SEND: begin
                if (ser_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gated by rst_n so the link sees no ready while reset is held.
    assign link_ready_o = rst_n && ((state_q == IDLE) || (state_q == WR_COLLECT));
    assign mem_req_o    = (state_q == MEM_REQ);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;

    for (genvar b = 0; b < DATA_W/8; b++) begin : g_be
        assign mem_be_o[b] = strb_q[2*b] | strb_q[2*b+1];
    end

    nibble_bus_rsp_ser #(
        .DATA_W (DATA_W)
    ) u_rsp_ser (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (ser_load),
        .single_i     (ser_single),
        .word_i       (ser_word),
        .rsp_nibble_o (link_rsp_nibble_o),
        .rsp_valid_o  (link_rsp_valid_o),
        .rsp_ready_i  (link_rsp_ready_i),
        .done_o       (ser_done)
    );

endmodule

// File: tb/tb_nibble_bus_responder.sv
// Self-checking bench for nibble_bus_responder: table vectors, directed corner
// sequences and randomized traffic against a word-level memory model.
module tb_nibble_bus_responder;

`ifdef NIBBLE_BUS_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  link_nibble_i;
    logic        link_strb_i;
    logic [7:0]  link_addr_i;
    logic        link_write_i;
    logic        link_valid_i;
    logic        link_ready_o;
    logic [3:0]  link_rsp_nibble_o;
    logic        link_rsp_valid_o;
    logic        link_rsp_ready_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    nibble_bus_responder #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .link_nibble_i     (link_nibble_i),
        .link_strb_i       (link_strb_i),
        .link_addr_i       (link_addr_i),
        .link_write_i      (link_write_i),
        .link_valid_i      (link_valid_i),
        .link_ready_o      (link_ready_o),
        .link_rsp_nibble_o (link_rsp_nibble_o),
        .link_rsp_valid_o  (link_rsp_valid_o),
        .link_rsp_ready_i  (link_rsp_ready_i),
        .mem_req_o         (mem_req_o),
        .mem_gnt_i         (mem_gnt_i),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_be_o          (mem_be_o),
        .mem_rvalid_i      (mem_rvalid_i),
        .mem_rdata_i       (mem_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  strb;
        logic [3:0]  be;
    } vec_t;

    int total;
    int bad;
    int cyc;
    int gnt_dly;
    int rd_dly;
    int rsp_mode;
    int rv_cyc;
    int vld_rise_cyc;
    logic [31:0] dev_mem [256];
    logic [31:0] ref_mem [256];
    req_t        req_q [$];
    logic [3:0]  rsp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_be(input logic [7:0] s);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = s[2*i] | s[2*i+1];
        return be;
    endfunction

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    // Memory side: grants after gnt_dly cycles, returns read data rd_dly cycles after grant.
    initial begin : mem_side
        int   wait_cnt;
        int   rd_cnt;
        bit   rd_pend;
        bit   pend;
        req_t snap;
        logic [31:0] rd_word;
        wait_cnt = 0; rd_cnt = 0; rd_pend = 0; pend = 0; rd_word = '0;
        snap = '{1'b0, 8'h0, 32'h0, 4'h0};
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            if (!rst_n) begin
                wait_cnt = 0; rd_pend = 0; pend = 0;
            end else begin
                if (rd_pend) begin
                    if (rd_cnt == 0) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = rd_word;
                        rd_pend      = 0;
                        rv_cyc       = cyc;
                    end else rd_cnt--;
                end
                if (pend) begin
                    chk("mem_req_held", mem_req_o, 1);
                    chk("mem_attr_held", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
                        {snap.we, snap.addr, snap.wdata, snap.be});
                end
                if (mem_req_o) begin
                    if (wait_cnt < gnt_dly) begin
                        wait_cnt++;
                        pend = 1;
                        snap = '{mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};
                    end else begin
                        mem_gnt_i = 1'b1;
                        wait_cnt  = 0;
                        pend      = 0;
                        req_q.push_back('{mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o});
                        if (mem_we_o) begin
                            for (int b = 0; b < 4; b++)
                                if (mem_be_o[b]) dev_mem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
                        end else begin
                            rd_pend = 1;
                            rd_cnt  = rd_dly - 1;
                            rd_word = dev_mem[mem_addr_o];
                        end
                    end
                end else pend = 0;
            end
        end
    end

    // Response side: ready pattern per rsp_mode, collects nibbles, checks payload hold.
    initial begin : rsp_side
        bit         pend;
        bit         prev_v;
        bit         tog;
        logic [3:0] snap;
        pend = 0; prev_v = 0; tog = 0; snap = '0;
        link_rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            case (rsp_mode)
                0:       link_rsp_ready_i = 1'b1;
                1:       begin tog = !tog; link_rsp_ready_i = tog; end
                default: link_rsp_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (!rst_n) begin
                pend = 0; prev_v = 0;
            end else begin
                if (pend) begin
                    chk("rsp_valid_held", link_rsp_valid_o, 1);
                    chk("rsp_nibble_held", link_rsp_nibble_o, snap);
                end
                if (link_rsp_valid_o && !prev_v) vld_rise_cyc = cyc;
                if (link_rsp_valid_o && link_rsp_ready_i) begin
                    rsp_q.push_back(link_rsp_nibble_o);
                    pend = 0;
                end else if (link_rsp_valid_o) begin
                    pend = 1;
                    snap = link_rsp_nibble_o;
                end else pend = 0;
                prev_v = link_rsp_valid_o;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic beat(input logic w, input logic [7:0] a, input logic [3:0] n, input logic s);
        int t;
        t = 0;
        link_valid_i = 1'b1; link_write_i = w; link_addr_i = a;
        link_nibble_i = n; link_strb_i = s;
        while (!link_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("beat_ready_timeout", link_ready_o, 1);
        @(negedge clk);
        link_valid_i = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!link_ready_o && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("idle_timeout", link_ready_o, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [7:0] s,
                            input logic [3:0] be, input bit gaps);
        req_t r;
        rsp_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            // Address/write on later beats are junk the DUT must ignore.
            beat(i == 0 ? 1'b1 : 1'($urandom_range(0, 1)), i == 0 ? a : 8'($urandom),
                 d[4*i +: 4], s[i]);
        end
        chk("wr_req_latency", mem_req_o, be != 4'h0);
        wait_ready();
        if (be != 4'h0) begin
            chk("wr_req_cnt", req_q.size(), 1);
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                chk("wr_we", r.we, 1);
                chk("wr_addr", r.addr, a);
                chk("wr_wdata", r.wdata, d);
                chk("wr_be", r.be, be);
            end
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end else begin
            chk("wr_noreq", req_q.size(), 0);
        end
        chk("wr_rsp_cnt", rsp_q.size(), ACK ? 1 : 0);
        if (rsp_q.size() == 1) chk("wr_ack", rsp_q[0], 4'hA);
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] w);
        req_t r;
        rsp_q.delete();
        w = '0;
        beat(1'b0, a, 4'($urandom), 1'($urandom));
        chk("rd_req_latency", mem_req_o, 1);
        wait_ready();
        chk("rd_req_cnt", req_q.size(), 1);
        if (req_q.size() > 0) begin
            r = req_q.pop_front();
            chk("rd_we", r.we, 0);
            chk("rd_addr", r.addr, a);
        end
        chk("rd_rsp_cnt", rsp_q.size(), 8);
        for (int i = 0; i < 8 && i < rsp_q.size(); i++) w[4*i +: 4] = rsp_q[i];
        chk("rd_data", w, ref_mem[a]);
        chk("rd_rsp_latency", vld_rise_cyc, rv_cyc + 1);
    endtask

    initial begin : main
        vec_t        tv [7];
        logic [31:0] w;
        logic [7:0]  s;
        logic [7:0]  a;
        total = 0; bad = 0;
        gnt_dly = 0; rd_dly = 1; rsp_mode = 0; rv_cyc = 0; vld_rise_cyc = 0;
        rst_n = 1'b0;
        link_valid_i = 1'b0; link_write_i = 1'b0; link_addr_i = '0;
        link_nibble_i = '0; link_strb_i = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'(i * 3)};
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[5] = 32'hDEADBEEF;
        dev_mem[5] = 32'hDEADBEEF;

        tv[0] = '{1'b1, 8'h12, 32'h12345678, 8'hFF, 4'hF};
        tv[1] = '{1'b1, 8'h20, 32'hA5A51234, 8'h03, 4'h1};
        tv[2] = '{1'b1, 8'h21, 32'hFFFFFFFF, 8'h00, 4'h0};
        tv[3] = '{1'b1, 8'h22, 32'h0BADCAFE, 8'h81, 4'h9};
        tv[4] = '{1'b1, 8'h23, 32'h13572468, 8'h24, 4'h6};
        tv[5] = '{1'b0, 8'h12, 32'h0, 8'h00, 4'h0};
        tv[6] = '{1'b0, 8'h20, 32'h0, 8'h00, 4'h0};

        repeat (3) @(negedge clk);
        chk("rst_link_ready", link_ready_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_be", mem_be_o, 0);
        chk("rst_rsp_valid", link_rsp_valid_o, 0);
        chk("rst_rsp_nibble", link_rsp_nibble_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", link_ready_o, 1);

        for (int i = 0; i < 7; i++) begin
            if (tv[i].we) do_write(tv[i].addr, tv[i].data, tv[i].strb, tv[i].be, 1'b0);
            else do_read(tv[i].addr, w);
        end

        // Read with slow rvalid; nibbles must come back F,E,E,B,D,A,E,D.
        rd_dly = 3;
        do_read(8'h05, w);
        chk("t3_word", w, 32'hDEADBEEF);

        // Delayed grant and toggling response ready.
        gnt_dly = 4; rsp_mode = 1; rd_dly = 2;
        do_write(8'h30, 32'h89ABCDEF, 8'hF0, 4'hC, 1'b1);
        do_read(8'h30, w);

        // Reset after 3 write nibbles: the write must vanish.
        gnt_dly = 0; rsp_mode = 0; rd_dly = 1;
        beat(1'b1, 8'h40, 4'h1, 1'b1);
        beat(1'b1, 8'h40, 4'h2, 1'b1);
        beat(1'b1, 8'h40, 4'h3, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_ready", link_ready_o, 0);
        chk("midrst_req", mem_req_o, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_noreq", req_q.size(), 0);
        do_read(8'h05, w);
        chk("midrst_read", w, 32'hDEADBEEF);
        do_read(8'h40, w);

        rsp_mode = 2;
        for (int n = 0; n < 40; n++) begin
            gnt_dly = $urandom_range(0, 3);
            rd_dly  = $urandom_range(1, 4);
            a = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                do_write(a, $urandom, s, exp_be(s), 1'b1);
            end else begin
                do_read(a, w);
            end
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
